// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD refresh path: sequencer state
// encoding, panel geometry and default handshake timeout.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } lcd_state_e;

  localparam int unsigned LCD_POSITIONS   = 32;
  localparam int unsigned LCD_LINE_LEN    = 16;
  localparam logic [7:0]  ASCII_SPACE     = 8'h20;
  localparam int unsigned LCD_ACK_TIMEOUT = 16;

endpackage

// File: rtl/lcd_shadow_buffer.sv
// Shadow frame buffer: character storage plus per-position dirty flags,
// written by the host and read/cleared by the refresh sequencer at ptr.
module lcd_shadow_buffer
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_POS    = LCD_POSITIONS,
  parameter logic [7:0]  BLANK_CHAR = ASCII_SPACE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh_all,
  input  logic [4:0] ptr,
  input  logic       clear_dirty,
  input  logic       set_dirty,
  output logic [7:0] rd_data,
  output logic       dirty_at_ptr,
  output logic       any_dirty
);

  logic [7:0]         mem_q [NUM_POS];
  logic [7:0]         mem_d [NUM_POS];
  logic [NUM_POS-1:0] dirty_q;
  logic [NUM_POS-1:0] dirty_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Sets are applied after the clear so a host write to the position being
  // issued keeps it pending for a later pass.
  always_comb begin
    dirty_d = dirty_q;
    if (clear_dirty) dirty_d[ptr] = 1'b0;
    if (set_dirty)   dirty_d[ptr] = 1'b1;
    if (wr_en)       dirty_d[wr_addr] = 1'b1;
    if (refresh_all) dirty_d = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_POS; i++) begin
        mem_q[i] <= BLANK_CHAR;
      end
      dirty_q <= '1;
    end else begin
      mem_q   <= mem_d;
      dirty_q <= dirty_d;
    end
  end

  assign rd_data      = mem_q[ptr];
  assign dirty_at_ptr = dirty_q[ptr];
  assign any_dirty    = |dirty_q;

endmodule

// File: rtl/lcd_refresh_sequencer.sv
// Round-robin refresh sequencer: scans the shadow buffer and pushes dirty
// characters one at a time through the lcd_controller ready handshake.
module lcd_refresh_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_POS     = LCD_POSITIONS,
  parameter int unsigned ACK_TIMEOUT = LCD_ACK_TIMEOUT,
  parameter logic [7:0]  BLANK_CHAR  = ASCII_SPACE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       buf_we,
  input  logic [4:0] buf_addr,
  input  logic [7:0] buf_data,
  input  logic       refresh_all,
  input  logic       lcd_ready,
  output logic [7:0] lcd_char,
  output logic [4:0] lcd_pos,
  output logic       lcd_we,
  output logic       busy,
  output logic       idle,
  output logic       ack_err
);

  localparam int unsigned CW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACK_TIMEOUT);
  localparam logic [4:0]  LAST_POS = 5'(NUM_POS - 1);

  lcd_state_e    state_q, state_d;
  logic [4:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    char_q, char_d;
  logic [4:0]    pos_q, pos_d;
  logic          err_q, err_d;

  logic       clear_dirty, set_dirty;
  logic [7:0] rd_data;
  logic       dirty_at_ptr, any_dirty;
  logic [4:0] next_ptr;

  lcd_shadow_buffer #(
    .NUM_POS    (NUM_POS),
    .BLANK_CHAR (BLANK_CHAR)
  ) u_shadow (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (buf_we),
    .wr_addr      (buf_addr),
    .wr_data      (buf_data),
    .refresh_all  (refresh_all),
    .ptr          (ptr_q),
    .clear_dirty  (clear_dirty),
    .set_dirty    (set_dirty),
    .rd_data      (rd_data),
    .dirty_at_ptr (dirty_at_ptr),
    .any_dirty    (any_dirty)
  );

  assign next_ptr = (ptr_q == LAST_POS) ? '0 : ptr_q + 5'd1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    char_d      = char_q;
    pos_d       = pos_q;
    err_d       = err_q;
    clear_dirty = 1'b0;
    set_dirty   = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (dirty_at_ptr && lcd_ready) begin
          state_d = ST_ISSUE;
          char_d  = rd_data;
          pos_d   = ptr_q;
        end else begin
          ptr_d = next_ptr;
        end
      end
      ST_ISSUE: begin
        clear_dirty = 1'b1;
        cnt_d       = CNT_LOAD;
        state_d     = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!lcd_ready) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          // Counter hits zero this cycle: give up, keep the position pending.
          if (cnt_q <= CW'(1)) begin
            set_dirty = 1'b1;
            err_d     = 1'b1;
            ptr_d     = next_ptr;
            state_d   = ST_SCAN;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (lcd_ready) begin
          ptr_d   = next_ptr;
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SCAN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      char_q  <= '0;
      pos_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
    end
  end

  assign lcd_we   = (state_q == ST_ISSUE);
  assign lcd_char = char_q;
  assign lcd_pos  = pos_q;
  assign busy     = (state_q != ST_SCAN);
  assign idle     = !any_dirty && (state_q == ST_SCAN);
  assign ack_err  = err_q;

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// Directed bench for lcd_refresh_sequencer with a behavioural lcd_controller
// ready model and a log of every character issued.
module tb_lcd_refresh_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       buf_we;
  logic [4:0] buf_addr;
  logic [7:0] buf_data;
  logic       refresh_all;
  logic       lcd_ready;
  logic [7:0] lcd_char;
  logic [4:0] lcd_pos;
  logic       lcd_we;
  logic       busy;
  logic       idle;
  logic       ack_err;

  lcd_refresh_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .buf_we      (buf_we),
    .buf_addr    (buf_addr),
    .buf_data    (buf_data),
    .refresh_all (refresh_all),
    .lcd_ready   (lcd_ready),
    .lcd_char    (lcd_char),
    .lcd_pos     (lcd_pos),
    .lcd_we      (lcd_we),
    .busy        (busy),
    .idle        (idle),
    .ack_err     (ack_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Ready model modes: 0 = controller (busy 10 cycles after each write),
  // 1 = stuck high (never acknowledges), 2 = stuck low.
  int rdy_mode = 0;
  int hold     = 0;
  bit pend     = 1'b0;

  logic [7:0] log_char[$];
  logic [4:0] log_pos[$];
  int         log_cyc[$];
  logic [7:0] exp_buf[32];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    lcd_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (lcd_we === 1'b1) begin
        log_char.push_back(lcd_char);
        log_pos.push_back(lcd_pos);
        log_cyc.push_back(cyc);
      end
      case (rdy_mode)
        1: lcd_ready = 1'b1;
        2: lcd_ready = 1'b0;
        default: begin
          if (pend) begin
            lcd_ready = 1'b0;
            hold      = 10;
            pend      = 1'b0;
          end else if (hold > 0) begin
            hold--;
            if (hold == 0) lcd_ready = 1'b1;
          end
          if (lcd_we === 1'b1) pend = 1'b1;
        end
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic set_mode(input int m);
    @(negedge clk);
    #1;
    rdy_mode  = m;
    hold      = 0;
    pend      = 1'b0;
    lcd_ready = (m != 2);
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    buf_we   = 1'b1;
    buf_addr = a;
    buf_data = d;
    exp_buf[a] = d;
    @(negedge clk);
    buf_we = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (log_pos.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (idle === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0; buf_we = 1'b0; buf_addr = '0; buf_data = '0; refresh_all = 1'b0;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
    #22;
    total++; if (lcd_we !== 1'b0) begin bad++; $display("FAIL rst_lcd_we: got %b want 0", lcd_we); end
    total++; if (lcd_char !== 8'h00) begin bad++; $display("FAIL rst_lcd_char: got %h want 00", lcd_char); end
    total++; if (lcd_pos !== 5'd0) begin bad++; $display("FAIL rst_lcd_pos: got %0d want 0", lcd_pos); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL rst_idle: got %b want 0", idle); end
    total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL rst_ack_err: got %b want 0", ack_err); end
    @(negedge clk);
    log_char.delete(); log_pos.delete(); log_cyc.delete();
    rst_n = 1'b1;
    wait_log(32, 1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL blank_count: got %0d issues want 32", log_pos.size()); end
    for (int i = 0; i < 32 && i < log_pos.size(); i++) begin
      total++; if (log_pos[i] !== 5'(i)) begin bad++; $display("FAIL blank_pos[%0d]: got %0d want %0d", i, log_pos[i], i); end
      total++; if (log_char[i] !== 8'h20) begin bad++; $display("FAIL blank_char[%0d]: got %h want 20", i, log_char[i]); end
    end
    wait_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL blank_idle: got idle=%b want 1", idle); end
    repeat (40) @(negedge clk);
    total++; if (log_pos.size() != 32) begin bad++; $display("FAIL blank_no_extra: got %0d issues want 32", log_pos.size()); end
  endtask

  task automatic test_single_write();
    bit ok;
    int t;
    log_char.delete(); log_pos.delete(); log_cyc.delete();
    @(negedge clk);
    buf_we = 1'b1; buf_addr = 5'd5; buf_data = 8'h41; exp_buf[5] = 8'h41;
    t = cyc;
    @(negedge clk);
    buf_we = 1'b0;
    wait_log(1, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_issue: got %0d issues want 1", log_pos.size()); end
    if (ok) begin
      total++; if (log_cyc[0] - t > 33 || log_cyc[0] - t < 1) begin bad++; $display("FAIL single_latency: got %0d cycles want 1..33", log_cyc[0] - t); end
      total++; if (log_char[0] !== 8'h41) begin bad++; $display("FAIL single_char: got %h want 41", log_char[0]); end
      total++; if (log_pos[0] !== 5'd5) begin bad++; $display("FAIL single_pos: got %0d want 5", log_pos[0]); end
    end
    wait_idle(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_idle: got idle=%b want 1", idle); end
    total++; if (log_pos.size() != 1) begin bad++; $display("FAIL single_once: got %0d issues want 1", log_pos.size()); end
  endtask

  task automatic test_collision();
    bit ok;
    bit found;
    log_char.delete(); log_pos.delete(); log_cyc.delete();
    host_write(5'd20, 8'h42);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (lcd_we === 1'b1 && lcd_pos === 5'd20) begin found = 1'b1; break; end
      @(negedge clk);
    end
    // Rewrite lands on the same edge that clears dirty[20] in ISSUE.
    buf_we = 1'b1; buf_addr = 5'd20; buf_data = 8'h43; exp_buf[20] = 8'h43;
    @(negedge clk);
    buf_we = 1'b0;
    total++; if (!found) begin bad++; $display("FAIL coll_first_issue: got none want pos 20"); end
    total++; if (lcd_char !== 8'h42) begin bad++; $display("FAIL coll_char_held: got %h want 42", lcd_char); end
    wait_log(2, 120, ok);
    total++; if (!ok) begin bad++; $display("FAIL coll_count: got %0d issues want 2", log_pos.size()); end
    if (ok) begin
      total++; if (log_char[0] !== 8'h42 || log_pos[0] !== 5'd20) begin bad++; $display("FAIL coll_first: got %h@%0d want 42@20", log_char[0], log_pos[0]); end
      total++; if (log_char[1] !== 8'h43 || log_pos[1] !== 5'd20) begin bad++; $display("FAIL coll_second: got %h@%0d want 43@20", log_char[1], log_pos[1]); end
    end
    wait_idle(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL coll_idle: got idle=%b want 1", idle); end
    total++; if (log_pos.size() != 2) begin bad++; $display("FAIL coll_once_more: got %0d issues want 2", log_pos.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    bit seen;
    int t0;
    int t_err;
    set_mode(1);
    log_char.delete(); log_pos.delete(); log_cyc.delete();
    host_write(5'd9, 8'h55);
    wait_log(1, 40, ok);
    total++; if (!ok || log_pos[0] !== 5'd9) begin bad++; $display("FAIL to_issue: got %0d issues want pos 9", log_pos.size()); end
    t0 = ok ? log_cyc[0] : cyc;
    seen = 1'b0; t_err = 0;
    for (int i = 0; i < 40; i++) begin
      if (ack_err === 1'b1) begin seen = 1'b1; t_err = cyc; break; end
      @(negedge clk);
    end
    // WAIT_ACK spans ACK_TIMEOUT cycles after the single ISSUE cycle.
    total++; if (!seen || t_err - t0 != 17) begin bad++; $display("FAIL to_err_time: got %0d cycles (seen=%b) want 17", t_err - t0, seen); end
    wait_log(2, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_reissue: got %0d issues want 2", log_pos.size()); end
    if (ok) begin
      total++; if (log_cyc[1] - t0 != 49) begin bad++; $display("FAIL to_reissue_time: got %0d cycles want 49", log_cyc[1] - t0); end
      total++; if (log_pos[1] !== 5'd9 || log_char[1] !== 8'h55) begin bad++; $display("FAIL to_reissue_val: got %h@%0d want 55@9", log_char[1], log_pos[1]); end
    end
    total++; if (ack_err !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", ack_err); end
    set_mode(0);
    wait_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_recover_idle: got idle=%b want 1", idle); end
    total++; if (ack_err !== 1'b1) begin bad++; $display("FAIL to_sticky_after: got %b want 1", ack_err); end
  endtask

  task automatic test_ready_low();
    bit ok;
    int n_we;
    int n_busy;
    logic [31:0] seen;
    set_mode(2);
    log_char.delete(); log_pos.delete(); log_cyc.delete();
    @(negedge clk);
    refresh_all = 1'b1;
    buf_we = 1'b1; buf_addr = 5'd12; buf_data = 8'h5a; exp_buf[12] = 8'h5a;
    @(negedge clk);
    refresh_all = 1'b0; buf_we = 1'b0;
    n_we = 0; n_busy = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (lcd_we !== 1'b0) n_we++;
      if (busy !== 1'b0) n_busy++;
    end
    total++; if (n_we != 0) begin bad++; $display("FAIL low_no_we: got %0d strobes want 0", n_we); end
    total++; if (n_busy != 0) begin bad++; $display("FAIL low_not_busy: got %0d busy cycles want 0", n_busy); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL low_not_idle: got %b want 0", idle); end
    set_mode(0);
    wait_log(32, 1500, ok);
    total++; if (!ok) begin bad++; $display("FAIL low_resume: got %0d issues want 32", log_pos.size()); end
    seen = '0;
    for (int i = 0; i < log_pos.size(); i++) begin
      seen[log_pos[i]] = 1'b1;
      total++; if (log_char[i] !== exp_buf[log_pos[i]]) begin bad++; $display("FAIL low_char@%0d: got %h want %h", log_pos[i], log_char[i], exp_buf[log_pos[i]]); end
    end
    total++; if (seen !== 32'hffff_ffff) begin bad++; $display("FAIL low_coverage: got %h want ffffffff", seen); end
    wait_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL low_idle: got idle=%b want 1", idle); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    log_char.delete(); log_pos.delete(); log_cyc.delete();
    host_write(5'd3, 8'h61);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (lcd_we === 1'b1 && lcd_pos === 5'd3) begin found = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
    total++; if (!found || busy !== 1'b1) begin bad++; $display("FAIL mid_in_flight: got busy=%b found=%b want 1 1", busy, found); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (lcd_we !== 1'b0) begin bad++; $display("FAIL mid_lcd_we: got %b want 0", lcd_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL mid_ack_err: got %b want 0", ack_err); end
    total++; if (lcd_char !== 8'h00) begin bad++; $display("FAIL mid_lcd_char: got %h want 00", lcd_char); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL mid_idle: got %b want 0", idle); end
    hold = 0; pend = 1'b0; lcd_ready = 1'b1;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
    @(negedge clk);
    @(negedge clk);
    log_char.delete(); log_pos.delete(); log_cyc.delete();
    rst_n = 1'b1;
    wait_log(32, 1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_blank_count: got %0d issues want 32", log_pos.size()); end
    for (int i = 0; i < 32 && i < log_pos.size(); i++) begin
      total++; if (log_pos[i] !== 5'(i) || log_char[i] !== 8'h20) begin bad++; $display("FAIL mid_blank[%0d]: got %h@%0d want 20@%0d", i, log_char[i], log_pos[i], i); end
    end
    wait_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_idle_after: got idle=%b want 1", idle); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_collision();
    test_timeout();
    test_ready_low();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_refresh_sequencer.md
Name: lcd_refresh_sequencer

Overview:
Owns a 32-character shadow frame buffer (2 lines x 16) that the rest of the design writes at any rate. It schedules dirty characters one at a time into lcd_controller, using that block's char_data/cursor_pos/write_enable/ready handshake. Application logic never waits on LCD timing; the sequencer serializes all traffic to the single LCD resource.

Parameters:
NUM_POS, 32, character positions; 0-15 line 1, 16-31 line 2
ACK_TIMEOUT, 16, max cycles waiting for lcd_ready to drop after an issue
BLANK_CHAR, 8'h20, buffer contents after reset (ASCII space)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
buf_we  in  1  host write strobe, one write per cycle
buf_addr  in  5  host write position, 0-31
buf_data  in  8  host ASCII character
refresh_all  in  1  single-cycle pulse: mark all 32 positions dirty
lcd_ready  in  1  from lcd_controller ready
lcd_char  out  8  to lcd_controller char_data
lcd_pos  out  5  to lcd_controller cursor_pos
lcd_we  out  1  to lcd_controller write_enable
busy  out  1  transfer in flight (state != SCAN)
idle  out  1  no dirty positions and state == SCAN
ack_err  out  1  sticky; set on handshake timeout, cleared only by reset

Behaviour:
- Reset values: buffer = BLANK_CHAR everywhere, dirty = all ones (first refresh blanks the screen), ptr = 0, state = SCAN, lcd_we = 0, lcd_char = 8'h00, lcd_pos = 0, busy = 0, idle = 0, ack_err = 0.
- Host write: on buf_we, buf[buf_addr] <= buf_data and dirty[buf_addr] <= 1 in the same edge. Rewriting an identical value still marks the position dirty.
- refresh_all: sets every dirty bit. Combined with buf_we in the same cycle, both take effect.
- Registered state machine, states SCAN, ISSUE, WAIT_ACK, WAIT_DONE:
  - SCAN: if dirty[ptr] and lcd_ready, go to ISSUE. Otherwise ptr <= ptr+1, wrapping 31 to 0. The scan is round-robin, one position per cycle, so a full empty pass takes 32 cycles.
  - ISSUE (exactly 1 cycle): lcd_we = 1; lcd_char = buf[ptr] and lcd_pos = ptr, both registered on SCAN->ISSUE entry; dirty[ptr] cleared. Go to WAIT_ACK and load the timeout counter with ACK_TIMEOUT.
  - WAIT_ACK: lcd_we = 0. If lcd_ready == 0, go to WAIT_DONE. Else decrement the counter. When it reaches 0: set dirty[ptr], set ack_err, ptr <= ptr+1, go to SCAN.
  - WAIT_DONE: wait for lcd_ready == 1, with no timeout. Then ptr <= ptr+1 and go to SCAN.
- lcd_char and lcd_pos hold their values from ISSUE until the next ISSUE. The controller samples them over multiple cycles, so they must stay stable.
- Collision: buf_we to the address being cleared in ISSUE means the set wins. The dirty bit stays 1 and the new value is resent on a later pass. A host write to the in-flight position during WAIT_* does not alter lcd_char.
- Latency: a single dirty position with an idle scanner and lcd_ready high reaches lcd_we at most 33 cycles after buf_we.
- lcd_ready low in SCAN: no issue, and the scan continues.
- Reset mid-transfer returns immediately to reset values. lcd_we drops asynchronously.
- idle is combinational from the registered dirty vector and state. busy is combinational from state.

Decomposition:
- Shared package lcd_pkg holds: state enum, LCD_POSITIONS = 32, LCD_LINE_LEN = 16, ASCII_SPACE = 8'h20, and the default ACK_TIMEOUT constant.
- One sub-module: lcd_shadow_buffer. It contains the 32x8 register array and dirty vector, with a host write port, a read port at ptr, clear_dirty / set_dirty inputs at ptr, the set-over-clear priority, and the refresh_all set.

Test Plan:
- Reset with a ready model that drops ready 1 cycle after lcd_we and restores it after 10 cycles -> 32 issues with lcd_char = 8'h20 and lcd_pos = 0..31 in order, then idle = 1.
- After idle, buf_we addr = 5, data = 8'h41 -> exactly one lcd_we with lcd_char = 8'h41, lcd_pos = 5, within 33 cycles; idle returns to 1.
- Write addr 20 = 8'h42, then rewrite it with 8'h43 in the ISSUE cycle for position 20 -> two issues at pos 20, 8'h42 then 8'h43; dirty finally clear.
- Hold lcd_ready = 1 permanently -> ack_err rises exactly 16 cycles after ISSUE; the position is reissued on the next pass; ack_err stays 1.
- Hold lcd_ready = 0 with dirty bits pending -> no lcd_we, busy = 0. Raise ready -> issues resume.
- Assert rst_n low during WAIT_DONE -> lcd_we = 0, busy = 0, ack_err = 0 immediately. After release, the full 32-position blank refresh repeats.
